// File: rtl/ysyx_25020037_wbu.sv
// Write-back unit: formats the architectural result of one completed instruction,
// hands it to the register-file stage under valid/ready, and counts retirements.
module ysyx_25020037_wbu #(
  parameter int RET_CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_valid,
  output logic                 wbu_ready,
  input  logic [174:0]         lsu_to_wu_bus,
  output logic                 wbu_valid,
  input  logic                 gpr_ready,
  output logic [32:0]          wu_to_gu_bus,
  output logic [31:0]          csr_wcsr_data,
  output logic [31:0]          wb_pc,
  output logic                 retire,
  output logic [RET_CNT_W-1:0] retire_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        gpr_we;
    logic [1:0]  wb_sel;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] alu_res;
    logic [31:0] mem_rdata;
    logic [31:0] csr_rdata;
    logic [31:0] rs1_val;
    logic [1:0]  csr_op;
  } wb_req_t;

  typedef enum logic {IDLE, BUSY} state_t;

  wb_req_t     req;
  state_t      state, state_nxt;
  logic        accept, handoff;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data, gpr_wdata, csr_new;
  logic        gpr_wen;

  assign req = lsu_to_wu_bus;

  // ready/valid are pure decodes of the state flop, so still registered outputs
  assign wbu_ready = (state == IDLE);
  assign wbu_valid = (state == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    handoff   = 1'b0;
    case (state)
      IDLE: if (lsu_valid) begin
        accept    = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (gpr_ready) begin
        handoff   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // byte/half lane select; halfwords use only addr_lo[1]
  always_comb begin
    ld_b = req.mem_rdata[7:0];
    case (req.addr_lo)
      2'd0: ld_b = req.mem_rdata[7:0];
      2'd1: ld_b = req.mem_rdata[15:8];
      2'd2: ld_b = req.mem_rdata[23:16];
      2'd3: ld_b = req.mem_rdata[31:24];
      default: ld_b = req.mem_rdata[7:0];
    endcase
    ld_h = req.addr_lo[1] ? req.mem_rdata[31:16] : req.mem_rdata[15:0];
  end

  always_comb begin
    ld_data = req.mem_rdata;
    case (req.ld_type)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_data = {24'h0, ld_b};
      3'b101:  ld_data = {16'h0, ld_h};
      default: ld_data = req.mem_rdata;
    endcase
  end

  always_comb begin
    gpr_wdata = req.alu_res;
    case (req.wb_sel)
      2'b00:   gpr_wdata = req.alu_res;
      2'b01:   gpr_wdata = ld_data;
      2'b10:   gpr_wdata = req.csr_rdata;
      2'b11:   gpr_wdata = req.pc + 32'd4;
      default: gpr_wdata = req.alu_res;
    endcase
  end

  always_comb begin
    csr_new = req.csr_rdata;
    case (req.csr_op)
      2'b01:   csr_new = req.rs1_val;
      2'b10:   csr_new = req.csr_rdata | req.rs1_val;
      2'b11:   csr_new = req.csr_rdata & ~req.rs1_val;
      default: csr_new = req.csr_rdata;
    endcase
  end

  assign gpr_wen = req.gpr_we & (req.rd != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wu_to_gu_bus  <= '0;
      csr_wcsr_data <= '0;
      wb_pc         <= '0;
    end else if (accept) begin
      wu_to_gu_bus  <= {gpr_wen, gpr_wdata};
      csr_wcsr_data <= csr_new;
      wb_pc         <= req.pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      retire <= handoff;
      if (handoff) retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Bench for the write-back unit: directed literal cases plus a randomized run,
// all compared every cycle against a transaction-level model.
module tb_ysyx_25020037_wbu;

  localparam int CW = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        gpr_we;
    logic [1:0]  wb_sel;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] alu_res;
    logic [31:0] mem_rdata;
    logic [31:0] csr_rdata;
    logic [31:0] rs1_val;
    logic [1:0]  csr_op;
  } bus_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          lsu_valid = 1'b0;
  logic          wbu_ready;
  bus_t          lsu_to_wu_bus = '0;
  logic          wbu_valid;
  logic          gpr_ready = 1'b0;
  logic [32:0]   wu_to_gu_bus;
  logic [31:0]   csr_wcsr_data;
  logic [31:0]   wb_pc;
  logic          retire;
  logic [CW-1:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  ysyx_25020037_wbu #(.RET_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
    .lsu_to_wu_bus(lsu_to_wu_bus), .wbu_valid(wbu_valid), .gpr_ready(gpr_ready),
    .wu_to_gu_bus(wu_to_gu_bus), .csr_wcsr_data(csr_wcsr_data), .wb_pc(wb_pc),
    .retire(retire), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic bus_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                              input logic [1:0] sel, input logic [2:0] ld, input logic [1:0] al,
                              input logic [31:0] alu, input logic [31:0] mem,
                              input logic [31:0] csr, input logic [31:0] rs1, input logic [1:0] op);
    bus_t b;
    b.pc = pc; b.rd = rd; b.gpr_we = we; b.wb_sel = sel; b.ld_type = ld; b.addr_lo = al;
    b.alu_res = alu; b.mem_rdata = mem; b.csr_rdata = csr; b.rs1_val = rs1; b.csr_op = op;
    return b;
  endfunction

  // Reference result from the architectural rules, using integer arithmetic.
  function automatic logic [32:0] m_gpr(input bus_t b);
    longint v;
    longint m;
    int a;
    m = longint'(b.mem_rdata);
    a = int'(b.addr_lo);
    case (b.wb_sel)
      2'b00: v = longint'(b.alu_res);
      2'b10: v = longint'(b.csr_rdata);
      2'b11: v = (longint'(b.pc) + 4) % 64'h1_0000_0000;
      default: begin
        case (b.ld_type)
          3'b000: begin v = (m / (64'd1 << (8 * a))) % 256;      if (v >= 128)   v -= 256;   end
          3'b100: v = (m / (64'd1 << (8 * a))) % 256;
          3'b001: begin v = (m / (64'd1 << (16 * (a / 2)))) % 65536; if (v >= 32768) v -= 65536; end
          3'b101: v = (m / (64'd1 << (16 * (a / 2)))) % 65536;
          default: v = m;
        endcase
      end
    endcase
    return {(b.gpr_we && b.rd != 0), v[31:0]};
  endfunction

  function automatic logic [31:0] m_csr(input bus_t b);
    case (b.csr_op)
      2'b01:   return b.rs1_val;
      2'b10:   return b.csr_rdata | b.rs1_val;
      2'b11:   return b.csr_rdata & ~b.rs1_val;
      default: return b.csr_rdata;
    endcase
  endfunction

  // Transaction-level model: one pending instruction or none.
  logic        m_pend = 1'b0;
  logic        m_ret  = 1'b0;
  int          m_cnt  = 0;
  logic [32:0] m_gout = '0;
  logic [31:0] m_cout = '0;
  logic [31:0] m_pc   = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = 1'b0; m_ret = 1'b0; m_cnt = 0; m_gout = '0; m_cout = '0; m_pc = '0;
    end else begin
      m_ret = 1'b0;
      if (m_pend) begin
        if (gpr_ready) begin
          m_pend = 1'b0;
          m_ret  = 1'b1;
          m_cnt  = (m_cnt + 1) % (1 << CW);
        end
      end else if (lsu_valid) begin
        m_pend = 1'b1;
        m_gout = m_gpr(lsu_to_wu_bus);
        m_cout = m_csr(lsu_to_wu_bus);
        m_pc   = lsu_to_wu_bus.pc;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ready",  wbu_ready,     !m_pend);
    chk("m_valid",  wbu_valid,     m_pend);
    chk("m_retire", retire,        m_ret);
    chk("m_cnt",    retire_cnt,    m_cnt);
    chk("m_gpr",    wu_to_gu_bus,  m_gout);
    chk("m_csr",    csr_wcsr_data, m_cout);
    chk("m_pc",     wb_pc,         m_pc);
  end

  task automatic wait_valid(input string nm);
    for (int n = 0; n < 20 && !wbu_valid; n++) @(negedge clk);
    chk({nm, "_valid"}, wbu_valid, 1);
  endtask

  // One instruction with gpr_ready high; pins DUT outputs to literal values.
  task automatic send(input string nm, input bus_t b, input logic [32:0] eg, input logic [31:0] ec);
    @(negedge clk);
    lsu_valid = 1'b1; lsu_to_wu_bus = b; gpr_ready = 1'b1;
    @(negedge clk);
    wait_valid(nm);
    lsu_valid = 1'b0;
    chk({nm, "_gpr"}, wu_to_gu_bus, eg);
    chk({nm, "_csr"}, csr_wcsr_data, ec);
    @(negedge clk);
    chk({nm, "_retire"}, retire, 1);
    chk({nm, "_vdrop"}, wbu_valid, 0);
  endtask

  initial begin
    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lsu_valid = 1'($urandom); gpr_ready = 1'($urandom);
      lsu_to_wu_bus = bus_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    end
    chk("rst_ready", wbu_ready, 1);
    chk("rst_valid", wbu_valid, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_bus", wu_to_gu_bus, 0);
    lsu_valid = 1'b0; gpr_ready = 1'b0;
    @(negedge clk); rst = 1'b1;

    send("alu",  mk(32'h1000, 5, 1, 2'b00, 3'b010, 0, 32'h12345678, 0, 0, 0, 0), 33'h1_12345678, 32'h0);
    chk("alu_cnt", retire_cnt, 1);
    send("alu0", mk(32'h1004, 0, 1, 2'b00, 3'b010, 0, 32'h12345678, 0, 0, 0, 0), 33'h0_12345678, 32'h0);

    send("lb",  mk(32'h2000, 7, 1, 2'b01, 3'b000, 2, 0, 32'h80FF7F01, 0, 0, 0), 33'h1_FFFFFFFF, 0);
    send("lbu", mk(32'h2004, 7, 1, 2'b01, 3'b100, 3, 0, 32'h80FF7F01, 0, 0, 0), 33'h1_00000080, 0);
    send("lh",  mk(32'h2008, 7, 1, 2'b01, 3'b001, 2, 0, 32'h80FF7F01, 0, 0, 0), 33'h1_FFFF80FF, 0);
    send("lhu", mk(32'h200C, 7, 1, 2'b01, 3'b101, 1, 0, 32'h80FF7F01, 0, 0, 0), 33'h1_00007F01, 0);
    send("lw",  mk(32'h2010, 7, 1, 2'b01, 3'b010, 3, 0, 32'h80FF7F01, 0, 0, 0), 33'h1_80FF7F01, 0);

    send("csrrw", mk(32'h3000, 3, 1, 2'b10, 0, 0, 0, 0, 32'hF0F0F0F0, 32'h0000FFFF, 2'b01), 33'h1_F0F0F0F0, 32'h0000FFFF);
    send("csrrs", mk(32'h3004, 3, 1, 2'b10, 0, 0, 0, 0, 32'hF0F0F0F0, 32'h0000FFFF, 2'b10), 33'h1_F0F0F0F0, 32'hF0F0FFFF);
    send("csrrc", mk(32'h3008, 3, 1, 2'b10, 0, 0, 0, 0, 32'hF0F0F0F0, 32'h0000FFFF, 2'b11), 33'h1_F0F0F0F0, 32'hF0F00000);

    // back-pressure with a second instruction waiting
    @(negedge clk);
    lsu_valid = 1'b1; gpr_ready = 1'b0;
    lsu_to_wu_bus = mk(32'hFFFFFFFC, 1, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    wait_valid("bp");
    lsu_to_wu_bus = mk(32'h100, 2, 1, 2'b00, 0, 0, 32'hAAAA5555, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", wbu_ready, 0);
      chk("bp_gpr", wu_to_gu_bus, 33'h1_00000000);
      chk("bp_pc", wb_pc, 32'hFFFFFFFC);
    end
    gpr_ready = 1'b1;
    @(negedge clk);
    chk("bp_retire", retire, 1);
    chk("bp_nobypass", wbu_valid, 0);
    @(negedge clk);
    chk("bp_2nd_valid", wbu_valid, 1);
    chk("bp_2nd_pc", wb_pc, 32'h100);
    chk("bp_2nd_gpr", wu_to_gu_bus, 33'h1_AAAA5555);
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("bp_cnt", retire_cnt, 12);

    // asynchronous reset while BUSY drops the instruction
    @(negedge clk);
    lsu_valid = 1'b1; gpr_ready = 1'b0;
    lsu_to_wu_bus = mk(32'h4000, 9, 1, 2'b00, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    @(negedge clk);
    wait_valid("mr");
    lsu_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mr_valid", wbu_valid, 0);
    chk("mr_ready", wbu_ready, 1);
    chk("mr_bus", wu_to_gu_bus, 0);
    chk("mr_cnt", retire_cnt, 0);
    gpr_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_noret", retire, 0);

    // 16 retirements wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) begin
      send("wrap", mk(32'h5000 + 4 * i, 4, 1, 2'b00, 0, 0, 32'h1000 + i, 0, 0, 0, 0),
           {1'b1, 32'h1000 + i}, 32'h0);
      chk("wrap_cnt", retire_cnt, (i + 1) % 16);
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      lsu_valid = ($urandom_range(0, 2) != 0);
      gpr_ready = ($urandom_range(0, 3) != 0);
      lsu_to_wu_bus = bus_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 7) == 0) lsu_to_wu_bus.rd = 5'd0;
      if ($urandom_range(0, 7) == 0) lsu_to_wu_bus.pc = 32'hFFFFFFFC;
    end
    lsu_valid = 1'b0; gpr_ready = 1'b1;
    @(negedge clk); @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_wbu.md
# ysyx_25020037_wbu

Write-back unit of the multi-cycle core. It sits directly upstream of the GPR/CSR register-file stage. It accepts one completed instruction from the LSU, selects and formats the architectural result, and presents the GPR write (`wu_to_gu_bus`) and the CSR write value (`csr_wcsr_data`) to the register file under a valid/ready handshake. It also counts retired instructions.

## Interface
Parameters:
- `RET_CNT_W`, default 64: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `lsu_valid`  in  1  `lsu_to_wu_bus` holds a valid instruction.
- `wbu_ready`  out  1  WBU can accept an instruction this cycle.
- `lsu_to_wu_bus`  in  175  bus fields, MSB first:
  - `pc[31:0]`, `rd[4:0]`, `gpr_we`
  - `wb_sel[1:0]`: 00 alu, 01 load, 10 csr, 11 pc+4
  - `ld_type[2:0]`: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
  - `addr_lo[1:0]`, `alu_res[31:0]`, `mem_rdata[31:0]`, `csr_rdata[31:0]`, `rs1_val[31:0]`
  - `csr_op[1:0]`: 00 none, 01 rw, 10 rs, 11 rc
- `wbu_valid`  out  1  write-back data is valid for the GPR stage.
- `gpr_ready`  in  1  GPR stage accepts the write-back.
- `wu_to_gu_bus`  out  33  `{gpr_wen, gpr_wdata[31:0]}`.
- `csr_wcsr_data`  out  32  new CSR value.
- `wb_pc`  out  32  PC of the instruction being written back.
- `retire`  out  1  one-cycle pulse when an instruction retires.
- `retire_cnt`  out  `RET_CNT_W`  number of instructions retired.

## Operation
FSM states: IDLE, BUSY.

- IDLE:
  - `wbu_ready` = 1, `wbu_valid` = 0.
  - On `lsu_valid & wbu_ready` at an edge: latch the computed results into the output registers, set `wbu_ready` to 0 and `wbu_valid` to 1, and go to BUSY.
- BUSY:
  - Outputs are held stable. `lsu_valid` is ignored and `lsu_to_wu_bus` is not sampled.
  - On `wbu_valid & gpr_ready` at an edge: set `wbu_valid` to 0 and `wbu_ready` to 1, pulse `retire` to 1 for the next cycle, increment `retire_cnt`, and go to IDLE.
- There is no bypass. An instruction presented during BUSY, including the handoff cycle, is not accepted until IDLE.

GPR write enable:
- `gpr_wen = gpr_we & (rd != 0)`.

`gpr_wdata` by `wb_sel`:
- alu: `alu_res`.
- csr: `csr_rdata`, the old CSR value.
- pc+4: `pc + 4`, modulo 2^32 (0xFFFFFFFC gives 0x00000000).
- load: `mem_rdata` is first shifted right by `addr_lo*8`, then:
  - lb: sign-extend bits [7:0].
  - lbu: zero-extend bits [7:0].
  - lh/lhu: use `addr_lo[1]` only (bit 0 ignored); sign- or zero-extend bits [15:0].
  - lw: ignores `addr_lo`.
  - Undefined `ld_type` is treated as lw.

`csr_wcsr_data` by `csr_op`:
- rw: `rs1_val`.
- rs: `csr_rdata | rs1_val`.
- rc: `csr_rdata & ~rs1_val`.
- none: `csr_rdata`.

Other outputs:
- `wb_pc` is the latched `pc`.
- `retire_cnt` wraps from all-ones to 0.

## Timing
- Reset values:
  - state IDLE, `wbu_ready` 1, `wbu_valid` 0.
  - `wu_to_gu_bus` 0, `csr_wcsr_data` 0, `wb_pc` 0.
  - `retire` 0, `retire_cnt` 0.
- Latency: accept edge N gives `wbu_valid` = 1 during cycle N+1.
- Throughput: at best one instruction per 2 cycles. `wbu_valid` stays high for as many cycles as `gpr_ready` stays low.
- `retire` is high exactly during the cycle after the handshake edge and never high on consecutive cycles.
- Reset asserted mid-operation:
  - All registers take their reset values immediately, without waiting for a clock edge.
  - A BUSY instruction is dropped: no retire, no count.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold `rst`=0 with random inputs. Then `wbu_ready`=1, `wbu_valid`=0, `retire_cnt`=0, `wu_to_gu_bus`=0.
- **ALU write:** `wb_sel`=alu, `rd`=5, `gpr_we`=1, `alu_res`=0x12345678, `gpr_ready`=1.
  - `wbu_valid` is 1 for one cycle with `wu_to_gu_bus`={1, 0x12345678}.
  - `retire` pulses once and `retire_cnt`=1.
  - Repeat with `rd`=0: `gpr_wen`=0.
- **Load formatting:** `mem_rdata`=0x80FF7F01.
  - lb, `addr_lo`=2 → 0xFFFFFFFF.
  - lbu, `addr_lo`=3 → 0x00000080.
  - lh, `addr_lo`=2 → 0xFFFF80FF.
  - lhu, `addr_lo`=1 → 0x00007F01.
  - lw, `addr_lo`=3 → 0x80FF7F01.
- **CSR:** `csr_rdata`=0xF0F0F0F0, `rs1_val`=0x0000FFFF, `wb_sel`=csr.
  - rw → `csr_wcsr_data`=0x0000FFFF.
  - rs → 0xF0F0FFFF.
  - rc → 0xF0F00000.
  - `gpr_wdata`=0xF0F0F0F0 in every case.
- **Back-pressure:** hold `gpr_ready`=0 for 5 cycles while `lsu_valid`=1 with a second instruction.
  - Outputs are stable, `wbu_ready`=0, and the second instruction is not captured.
  - When `gpr_ready` rises, the first retires, then the second is accepted in IDLE.
  - `pc`=0xFFFFFFFC with pc+4 → 0x00000000.
- **Mid-reset and counter wrap:** assert `rst`=0 while BUSY; no `retire`, `retire_cnt` unchanged at 0. Then, with `RET_CNT_W`=4, retire 16 instructions; `retire_cnt` wraps 15 → 0.
